// File: rtl/anspwm_frame_sched_pkg.sv
// Shared types for the ANS-PWM frame scheduler: sample word, scheduler states
// and the fresh/stale result tag that travels alongside the stage chain.
package anspwm_pkg;

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic fresh;
    logic stale;
  } tag_t;

  localparam tag_t TAG_NONE = '{fresh: 1'b0, stale: 1'b0};

  function automatic tag_t make_tag(input logic is_fresh);
    make_tag = '{fresh: is_fresh, stale: ~is_fresh};
  endfunction

endpackage

// File: rtl/anspwm_frame_sched_frame_counter.sv
// Frame position counter: counts 0..PERIOD-1 while enabled and flags the last
// position of each frame.
module frame_counter
  import anspwm_pkg::*;
#(
  parameter int PERIOD = 256,
  parameter int CW     = $clog2(PERIOD)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q, count_d;

  // next frame position: clear wins over counting, wrap after the last position
  always_comb begin
    if (clr_i) begin
      count_d = {CW{1'b0}};
    end else if (en_i) begin
      count_d = (count_q == LAST) ? {CW{1'b0}} : count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // frame position register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i & (count_q == LAST);

endmodule

// File: rtl/anspwm_frame_sched.sv
// Frame scheduler: buffers one target sample, presents one target per PWM frame
// to the noise-shaping chain and flags whether each chain result is fresh or stale.
module anspwm_frame_sched
  import anspwm_pkg::*;
#(
  parameter int PERIOD  = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic [15:0] in_target,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] stg_target,
  output logic        stg_load,
  output logic        frame_tick,
  output logic        res_valid,
  output logic        res_stale,
  output logic        underrun,
  output logic        busy
);

  sched_state_t state_q, state_d;
  sample_t      hold_q, hold_d;
  logic         hold_full_q, hold_full_d;
  sample_t      stg_target_q, stg_target_d;
  tag_t         tag_q [LATENCY];
  tag_t         tag_d [LATENCY];

  logic tick_s, cnt_en_s, cnt_clr_s, ready_s, accept_s, load_s, in_flight_s;

  assign cnt_en_s  = (state_q != IDLE);
  assign cnt_clr_s = flush | ((state_q == IDLE) & enable);

  frame_counter #(.PERIOD(PERIOD)) u_frame_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .tick_o (tick_s)
  );

  // load/accept decisions, hold register, tag pipeline and next state
  always_comb begin
    ready_s  = ~hold_full_q & ((state_q == FILL) | (state_q == RUN));
    accept_s = in_valid & ready_s & ~flush;
    case (state_q)
      FILL:    load_s = tick_s & hold_full_q & enable & ~flush;
      RUN:     load_s = tick_s & ~flush;
      default: load_s = 1'b0;
    endcase

    // the tag leaving this clk is not counted as still in flight
    in_flight_s = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      in_flight_s = in_flight_s | tag_q[i].fresh | tag_q[i].stale;
    end

    stg_target_d = (load_s & hold_full_q) ? hold_q : stg_target_q;
    hold_d       = accept_s ? in_target : hold_q;
    if (flush) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_full_d = 1'b1;
    end else if (load_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    tag_d[0] = (load_s) ? make_tag(hold_full_q) : TAG_NONE;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_d[i] = TAG_NONE;
      end
    end else begin
      tag_d[0] = tag_d[0];
    end

    case (state_q)
      IDLE:    state_d = enable ? FILL : IDLE;
      FILL:    state_d = !enable ? IDLE : (load_s ? RUN : FILL);
      RUN:     state_d = enable ? RUN : DRAIN;
      DRAIN:   state_d = enable ? RUN : (in_flight_s ? DRAIN : IDLE);
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = enable ? FILL : IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // scheduler state, hold buffer, current target and tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= 16'h0000;
      hold_full_q  <= 1'b0;
      stg_target_q <= 16'h0000;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= TAG_NONE;
      end
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      stg_target_q <= stg_target_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // stg_target shows the new value already in the load clk and holds it after
  assign in_ready   = ready_s;
  assign stg_target = stg_target_d;
  assign stg_load   = load_s;
  assign frame_tick = tick_s;
  assign res_valid  = tag_q[LATENCY-1].fresh & ~flush;
  assign res_stale  = tag_q[LATENCY-1].stale & ~flush;
  assign underrun   = load_s & ~hold_full_q & (state_q == RUN);
  assign busy       = cnt_en_s;

endmodule

// File: tb/tb_anspwm_frame_sched.sv
// Bench for anspwm_frame_sched: directed vector table, corner sequences and
// randomized traffic checked against a frame/queue reference model.
module tb_anspwm_frame_sched;

  localparam int P   = 8;
  localparam int LAT = 3;
  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst, enable, flush, in_valid;
  logic [15:0] in_target;
  logic in_ready, stg_load, frame_tick, res_valid, res_stale, underrun, busy;
  logic [15:0] stg_target;
  logic [22:0] out_vec;

  assign out_vec = {in_ready, stg_target, stg_load, frame_tick, res_valid, res_stale, underrun, busy};

  always #5 clk = ~clk;

  anspwm_frame_sched #(.PERIOD(P), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_target(in_target), .in_valid(in_valid), .in_ready(in_ready),
    .stg_target(stg_target), .stg_load(stg_load), .frame_tick(frame_tick),
    .res_valid(res_valid), .res_stale(res_stale), .underrun(underrun), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_v, en_v, fl_v, vld_v;
  logic [15:0] din_v;

  // reference model state
  typedef struct { int due; bit fresh; } res_t;
  res_t m_q[$];
  int m_mode, m_pos;
  bit m_full, m_live;
  logic [15:0] m_hold, m_tgt;

  typedef struct { bit en; bit vld; logic [15:0] din; logic [22:0] exp; } vec_t;
  vec_t vec [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [22:0] mk(input bit rdy, input logic [15:0] s, input bit ld,
                                     input bit tk, input bit rv, input bit rs, input bit ur, input bit bz);
    mk = {rdy, s, ld, tk, rv, rs, ur, bz};
  endfunction

  task automatic model_step();
    bit e_busy, e_tick, e_ready, e_load, e_ur, e_rv, e_rs, exiting;
    logic [15:0] e_stg;
    e_busy  = (m_mode != M_IDLE);
    e_tick  = e_busy && (m_pos == P - 1);
    e_ready = (m_mode == M_FILL || m_mode == M_RUN) && !m_full;
    e_load  = !fl_v && e_tick && (m_mode == M_RUN || (m_mode == M_FILL && m_full && en_v));
    e_ur    = e_load && (m_mode == M_RUN) && !m_full;
    e_stg   = (e_load && m_full) ? m_hold : m_tgt;
    exiting = (m_q.size() > 0) && (m_q[0].due == cyc);
    e_rv    = exiting && !fl_v && m_q[0].fresh;
    e_rs    = exiting && !fl_v && !m_q[0].fresh;
    if (m_live) check("model", 32'(out_vec), 32'(mk(e_ready, e_stg, e_load, e_tick, e_rv, e_rs, e_ur, e_busy)));
    if (exiting) void'(m_q.pop_front());
    if (rst_v) begin
      m_mode = M_IDLE; m_pos = 0; m_full = 0; m_hold = 16'h0; m_tgt = 16'h0;
      m_q.delete();
      m_live = 1;
    end else if (fl_v) begin
      m_full = 0; m_q.delete(); m_pos = 0;
      m_mode = en_v ? M_FILL : M_IDLE;
    end else begin
      if (e_load) begin
        m_q.push_back(res_t'{due: cyc + LAT, fresh: m_full});
        m_tgt  = e_stg;
        m_full = 0;
      end
      if (vld_v && e_ready) begin
        m_hold = din_v;
        m_full = 1;
      end
      if (m_mode == M_IDLE) begin
        if (en_v) m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % P;
      end
      case (m_mode)
        M_IDLE:  m_mode = en_v ? M_FILL : M_IDLE;
        M_FILL:  m_mode = !en_v ? M_IDLE : (e_load ? M_RUN : M_FILL);
        M_RUN:   m_mode = en_v ? M_RUN : M_DRAIN;
        default: m_mode = en_v ? M_RUN : ((m_q.size() > 0) ? M_DRAIN : M_IDLE);
      endcase
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    rst = rst_v; enable = en_v; flush = fl_v; in_valid = vld_v; in_target = din_v;
    #1;
    model_step();
  endtask

  task automatic run_to_tick(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 3 * P && !got; k++) begin
      step();
      got = (frame_tick === 1'b1);
    end
    check(name, 32'(got), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int acc, n, vld_pct;
    rst_v = 1; en_v = 0; fl_v = 0; vld_v = 0; din_v = 16'h0;
    m_live = 0; m_mode = M_IDLE; m_pos = 0; m_full = 0; m_hold = 16'h0; m_tgt = 16'h0;
    step();
    step();
    rst_v = 0;

    // T1/T2: first fresh load, then two underrun frames
    for (int i = 0; i < 28; i++) begin
      vec[i].en  = 1'b1;
      vec[i].vld = 1'b0;
      vec[i].din = 16'h0000;
      vec[i].exp = mk(i == 1 || i == 2 || i >= 9, (i >= 8) ? 16'h1234 : 16'h0000,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i != 0);
    end
    vec[2].vld  = 1'b1;
    vec[2].din  = 16'h1234;
    vec[8].exp  = mk(1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vec[11].exp = mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vec[16].exp = mk(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vec[19].exp = mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vec[24].exp = vec[16].exp;
    vec[27].exp = vec[19].exp;
    for (int i = 0; i < 28; i++) begin
      en_v = vec[i].en; vld_v = vec[i].vld; din_v = vec[i].din;
      step();
      check($sformatf("table_row%0d", i), 32'(out_vec), 32'(vec[i].exp));
    end

    // T3: source held valid, exactly one accept per frame
    vld_v = 1; din_v = 16'hA000;
    run_to_tick("t3_sync_tick");
    for (int f = 0; f < 3; f++) begin
      acc = 0; seen = 0;
      for (int k = 0; k < 3 * P && !seen; k++) begin
        step();
        if (in_valid && in_ready) begin
          acc++;
          din_v = din_v + 16'h0001;
        end
        seen = (frame_tick === 1'b1);
      end
      check("t3_tick_seen", 32'(seen), 32'd1);
      check("t3_accepts_per_frame", 32'(acc), 32'd1);
    end

    // T4: enable dropped one clk after a fresh load
    vld_v = 0; en_v = 0;
    step();
    step();
    step();
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_busy_draining", 32'(busy), 32'd1);
    step();
    check("t4_busy_fell", 32'(busy), 32'd0);

    // T5: flush on a tick with a full hold in FILL
    en_v = 1; vld_v = 1; din_v = 16'hBEEF;
    step();
    step();
    vld_v = 0;
    for (int k = 0; k < 3 * P; k++) begin
      if (m_mode == M_FILL && m_pos == P - 1) break;
      step();
    end
    fl_v = 1;
    step();
    check("t5_flush_tick", 32'(frame_tick), 32'd1);
    check("t5_flush_quiet", 32'({stg_load, underrun, res_valid, res_stale}), 32'd0);
    fl_v = 0;
    for (n = 1; n <= 3 * P; n++) begin
      step();
      if (frame_tick === 1'b1) break;
    end
    check("t5_next_tick_dist", 32'(n), 32'(P));
    check("t5_no_load_fill", 32'(stg_load), 32'd0);

    // T6: reset mid-frame with tags in flight
    vld_v = 1; din_v = 16'h5A5A;
    step();
    vld_v = 0;
    run_to_tick("t6_load_tick");
    check("t6_loaded", 32'({stg_load, stg_target}), 32'h15A5A);
    step();
    rst_v = 1;
    step();
    rst_v = 0; en_v = 0;
    step();
    check("t6_reset_outputs", 32'(out_vec), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen = seen | res_valid | res_stale;
    end
    check("t6_no_res", 32'(seen), 32'd0);

    // randomized traffic against the reference model
    vld_pct = 50;
    en_v = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) vld_pct = (i % 600 == 0) ? 8 : ((i % 400 == 0) ? 90 : 40);
      n = int'($urandom_range(0, 999));
      rst_v = (n < 3);
      fl_v  = (n >= 3 && n < 15);
      if ($urandom_range(0, 99) < 4) en_v = ~en_v;
      vld_v = ($urandom_range(0, 99) < vld_pct);
      din_v = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
